simt_stack_param: RTL

- Parametrised per-warp SIMT divergence/reconvergence stack. Next generation of the fixed 8-warp/8-thread SIMT control block.
- Sits between Task Manager, Instruction Decode, ALU branch resolution, the Fetch PC unit and the IBuffer.
- Tracks each warp's active mask, pushes and pops divergence and call entries, and issues PC redirects and instruction drops.
- Adds configurable warps, threads and depth, CALL/RET frames, branch stall tracking, and overflow/underflow error flags.

---
 rtl/simt_stack_param.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/simt_stack_param.sv
// Per-warp SIMT divergence/reconvergence stack with CALL/RET frames,
// branch stall tracking and sticky overflow/underflow flags.
module simt_stack_param #(
    parameter int NUM_WARPS   = 8,
    parameter int NUM_THREADS = 8,
    parameter int DEPTH       = 4,
    parameter int PC_W        = 32,
    localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tm_init,
    input  logic [WID_W-1:0]               tm_wid,
    input  logic [NUM_THREADS-1:0]         tm_mask,
    input  logic                           id_valid,
    output logic                           id_ready,
    input  logic [WID_W-1:0]               id_wid,
    input  logic [2:0]                     id_op,
    input  logic [PC_W-1:0]                id_pcplus4,
    input  logic [PC_W-1:0]                id_target,
    input  logic                           alu_br_valid,
    input  logic [WID_W-1:0]               alu_wid,
    input  logic [NUM_THREADS-1:0]         alu_outcome,
    input  logic [PC_W-1:0]                alu_target,
    input  logic [PC_W-1:0]                alu_pcplus4,
    output logic [NUM_WARPS*NUM_THREADS-1:0] active_mask_flat,
    output logic [NUM_WARPS-1:0]           br_stall,
    output logic                           redir_valid,
    output logic [WID_W-1:0]               redir_wid,
    output logic [PC_W-1:0]                redir_pc,
    output logic [NUM_WARPS-1:0]           drop_instr,
    output logic [NUM_WARPS-1:0]           stack_empty,
    output logic [NUM_WARPS-1:0]           stack_err
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] P_DEPTH = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] P_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] P_TWO   = PTR_W'(2);

    localparam logic [2:0] OP_BR = 3'd0, OP_SYNC = 3'd1, OP_CALL = 3'd2, OP_RET = 3'd3;

    typedef enum logic [1:0] {
        T_DIV_PEND   = 2'd0,
        T_DIV_RECONV = 2'd1,
        T_CALL       = 2'd2
    } ent_type_t;

    typedef struct packed {
        ent_type_t              typ;
        logic [NUM_THREADS-1:0] mask;
        logic [PC_W-1:0]        pc;
    } entry_t;

    logic [NUM_THREADS-1:0] r_mask [NUM_WARPS];
    logic [PTR_W-1:0]       r_ptr  [NUM_WARPS];
    entry_t                 r_stk  [NUM_WARPS][DEPTH];
    logic [NUM_WARPS-1:0]   r_stall, r_err, r_drop;
    logic                   r_redir_valid;
    logic [WID_W-1:0]       r_redir_wid;
    logic [PC_W-1:0]        r_redir_pc;

    logic [NUM_THREADS-1:0] w_alu_mask, w_t, w_n;
    logic [PTR_W-1:0]       w_alu_ptr, w_id_ptr, w_id_ptr_m1;
    logic                   w_alu_fire, w_alu_div, w_alu_push, w_alu_err, w_alu_redir;
    logic                   w_id_empty, w_id_full, w_id_redir_req, w_id_ready, w_id_fire;
    entry_t                 w_top;

    // Resolve-side and decode-side decisions for this cycle.
    always_comb begin
        w_alu_mask  = r_mask[alu_wid];
        w_t         = alu_outcome & w_alu_mask;
        w_n         = w_alu_mask & ~alu_outcome;
        w_alu_ptr   = r_ptr[alu_wid];
        // tm_init on the same warp swallows the resolve entirely
        w_alu_fire  = alu_br_valid && r_stall[alu_wid] && !(tm_init && tm_wid == alu_wid);
        w_alu_div   = w_alu_fire && (w_t != '0) && (w_n != '0);
        w_alu_push  = w_alu_div && ((P_DEPTH - w_alu_ptr) >= P_TWO);
        w_alu_err   = w_alu_div && !w_alu_push;
        w_alu_redir = w_alu_fire && (w_t != '0);

        w_id_ptr    = r_ptr[id_wid];
        w_id_ptr_m1 = w_id_ptr - P_ONE;
        w_id_empty  = (w_id_ptr == '0);
        w_id_full   = (w_id_ptr == P_DEPTH);
        w_top       = r_stk[id_wid][w_id_ptr_m1[IDX_W-1:0]];

        w_id_redir_req = 1'b0;
        case (id_op)
            OP_SYNC: w_id_redir_req = !w_id_empty && (w_top.typ == T_DIV_PEND);
            OP_CALL: w_id_redir_req = !w_id_full;
            OP_RET:  w_id_redir_req = !w_id_empty && (w_top.typ == T_CALL);
            default: w_id_redir_req = 1'b0;
        endcase

        // A decode redirect that collides with an ALU redirect is held off
        w_id_ready = !(alu_br_valid && alu_wid == id_wid)
                  && !(tm_init && tm_wid == id_wid)
                  && !r_stall[id_wid]
                  && !(w_alu_redir && w_id_redir_req);
        w_id_fire  = id_valid && w_id_ready;
    end

    // Per-warp control state: masks, pointers, stall/error flags, redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_mask[w] <= '0;
                r_ptr[w]  <= '0;
            end
            r_stall       <= '0;
            r_err         <= '0;
            r_drop        <= '0;
            r_redir_valid <= 1'b0;
            r_redir_wid   <= '0;
            r_redir_pc    <= '0;
        end else begin
            r_redir_valid <= 1'b0;
            r_drop        <= '0;

            if (w_alu_fire) begin
                r_stall[alu_wid] <= 1'b0;
                if (w_alu_push) begin
                    r_ptr[alu_wid]  <= w_alu_ptr + P_TWO;
                    r_mask[alu_wid] <= w_t;
                end
                if (w_alu_err) r_err[alu_wid] <= 1'b1;
            end

            if (w_id_fire) begin
                case (id_op)
                    OP_BR: r_stall[id_wid] <= 1'b1;
                    OP_SYNC: if (!w_id_empty && w_top.typ != T_CALL) begin
                        r_ptr[id_wid]  <= w_id_ptr_m1;
                        r_mask[id_wid] <= w_top.mask;
                    end
                    OP_CALL: begin
                        if (!w_id_full) r_ptr[id_wid] <= w_id_ptr + P_ONE;
                        else            r_err[id_wid] <= 1'b1;
                    end
                    OP_RET: begin
                        if (!w_id_empty && w_top.typ == T_CALL) begin
                            r_ptr[id_wid]  <= w_id_ptr_m1;
                            r_mask[id_wid] <= w_top.mask;
                        end else begin
                            r_err[id_wid] <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_alu_redir) begin
                r_redir_valid <= 1'b1;
                r_redir_wid   <= alu_wid;
                r_redir_pc    <= alu_target;
                r_drop        <= NUM_WARPS'(1) << alu_wid;
            end else if (w_id_fire && w_id_redir_req) begin
                r_redir_valid <= 1'b1;
                r_redir_wid   <= id_wid;
                r_redir_pc    <= (id_op == OP_CALL) ? id_target : w_top.pc;
                r_drop        <= NUM_WARPS'(1) << id_wid;
            end

            // Last assignment wins: initialisation overrides anything above on this warp
            if (tm_init) begin
                r_mask[tm_wid]  <= tm_mask;
                r_ptr[tm_wid]   <= '0;
                r_stall[tm_wid] <= 1'b0;
                r_err[tm_wid]   <= 1'b0;
            end
        end
    end

    // Stack entry storage, written on pushes only.
    // NOTE: entries are not reset; a zero pointer marks them invalid, so clearing storage adds nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_alu_push) begin
                r_stk[alu_wid][w_alu_ptr[IDX_W-1:0]] <=
                    entry_t'{typ: T_DIV_RECONV, mask: w_alu_mask, pc: alu_pcplus4};
                r_stk[alu_wid][IDX_W'(w_alu_ptr + P_ONE)] <=
                    entry_t'{typ: T_DIV_PEND, mask: w_n, pc: alu_pcplus4};
            end
            if (w_id_fire && id_op == OP_CALL && !w_id_full) begin
                r_stk[id_wid][w_id_ptr[IDX_W-1:0]] <=
                    entry_t'{typ: T_CALL, mask: r_mask[id_wid], pc: id_pcplus4};
            end
        end
    end

    // Flatten per-warp state onto the output vectors.
    always_comb begin
        active_mask_flat = '0;
        stack_empty      = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            active_mask_flat[w*NUM_THREADS +: NUM_THREADS] = r_mask[w];
            stack_empty[w] = (r_ptr[w] == '0);
        end
    end

    assign id_ready    = w_id_ready;
    assign br_stall    = r_stall;
    assign stack_err   = r_err;
    assign redir_valid = r_redir_valid;
    assign redir_wid   = r_redir_wid;
    assign redir_pc    = r_redir_pc;
    assign drop_instr  = r_drop;

endmodule
